// File: rtl/sop_pkg.sv
// Shared types and default sizes for the streaming sum-of-products unit.
package sop_pkg;

    localparam int SOP_WIDTH     = 18;
    localparam int SOP_MAX_TERMS = 3;
    localparam int SOP_CNT_W     = 8;

    typedef logic [SOP_WIDTH-1:0] word_t;

    typedef struct packed {
        word_t p;
        logic  last;
    } p_stage_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_RESULT = 2'd2
    } sop_state_e;

endpackage

// File: rtl/sop_mul_stage.sv
// Product register: captures the truncated product of an accepted operand pair.
module sop_mul_stage
    import sop_pkg::*;
#(
    parameter int WIDTH = SOP_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             last_i,
    output logic             p_valid_o,
    output logic [WIDTH-1:0] p_o,
    output logic             p_last_o
);

    logic [WIDTH-1:0] prod_d;
    logic [WIDTH-1:0] p_q;
    logic             last_q;
    logic             valid_q;

    // A WIDTH-wide multiply context yields exactly the low WIDTH bits of the full product.
    assign prod_d = a_i * b_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            p_q     <= '0;
            last_q  <= 1'b0;
        end else if (adv_i) begin
            valid_q <= in_valid_i;
            if (in_valid_i) begin
                p_q    <= prod_d;
                last_q <= last_i;
            end
        end
    end

    assign p_valid_o = valid_q;
    assign p_o       = p_q;
    assign p_last_o  = last_q;

endmodule

// File: rtl/sop_stream_acc.sv
// Streaming sum-of-products: one product term per cycle into an accumulator,
// one registered result word per sum (flagged by in_last).
module sop_stream_acc
    import sop_pkg::*;
#(
    parameter int WIDTH     = SOP_WIDTH,
    parameter int MAX_TERMS = SOP_MAX_TERMS,
    parameter int CNT_W     = SOP_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_terms,
    output logic             out_ovf,
    output logic [1:0]       dbg_state
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_TERMS);

    logic             p_valid;
    logic [WIDTH-1:0] p_data;
    logic             p_last;
    logic             p_adv;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] out_terms_q, out_terms_d;
    logic             out_ovf_q, out_ovf_d;

    logic [WIDTH-1:0] sum;
    logic [CNT_W-1:0] cnt_n;
    sop_state_e       state;

    // Only a last term waiting on an unaccepted result can block the pipe.
    assign p_adv    = !p_valid || !p_last || !out_valid_q || out_ready;
    assign in_ready = p_adv;

    sop_mul_stage #(.WIDTH(WIDTH)) u_mul (
        .clk        (clk),
        .rst        (rst),
        .adv_i      (p_adv),
        .in_valid_i (in_valid),
        .a_i        (in_a),
        .b_i        (in_b),
        .last_i     (in_last),
        .p_valid_o  (p_valid),
        .p_o        (p_data),
        .p_last_o   (p_last)
    );

    assign sum   = acc_q + p_data;
    assign cnt_n = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_terms_d = out_terms_q;
        out_ovf_d   = out_ovf_q;
        if (p_valid && p_adv) begin
            if (p_last) begin
                out_data_d  = sum;
                out_terms_d = cnt_n;
                out_ovf_d   = (cnt_n > MAX_C);
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_n;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_terms_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_terms_q <= out_terms_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    // Observable state: a pending result dominates; otherwise a partial sum means ACCUM.
    always_comb begin
        state = ST_IDLE;
        if (out_valid_q) begin
            state = ST_RESULT;
        end else if (cnt_q != '0) begin
            state = ST_ACCUM;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_terms = out_terms_q;
    assign out_ovf   = out_ovf_q;
    assign dbg_state = state;

endmodule
